// File: rtl/dtree_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dtree_pkg
// Purpose : Shared types, cfg_field map and width helpers for dtree_mc.
// Revision: 1.0 - initial release
// ============================================================================
package dtree_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Returns at least 1 so that single-entry dimensions still get an index bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w(input int in_w, input int coeff_w, input int features);
    return in_w + coeff_w + clog2(features);
  endfunction

  function automatic int field_thresh(input int features);
    return features;
  endfunction

  function automatic int field_leaf(input int features);
    return features + 1;
  endfunction

  localparam int DEF_FEATURES = 3;
  localparam int FIELD_THRESH = field_thresh(DEF_FEATURES);
  localparam int FIELD_LEAF   = field_leaf(DEF_FEATURES);

endpackage
`default_nettype wire

// File: rtl/dtree_mc_node_eval.sv
`default_nettype none
// ============================================================================
// Module  : dtree_node_eval
// Purpose : Signed dot product of one node's coefficients with the history,
//           compared against the node threshold (d = 1 means go right).
// Revision: 1.0 - initial release
// ============================================================================
module dtree_node_eval
  import dtree_pkg::*;
#(
  parameter  int FEATURES    = 3,
  parameter  int IN_WIDTH    = 10,
  parameter  int COEFF_WIDTH = 4,
  localparam int ACC_W       = acc_w(IN_WIDTH, COEFF_WIDTH, FEATURES),
  localparam int PROD_W      = IN_WIDTH + COEFF_WIDTH
) (
  input  logic signed [IN_WIDTH-1:0]    x_i     [FEATURES],
  input  logic signed [COEFF_WIDTH-1:0] coeff_i [FEATURES],
  input  logic signed [ACC_W-1:0]       thresh_i,
  output logic                          d_o
);

  logic signed [PROD_W-1:0] prod [FEATURES];
  logic signed [ACC_W-1:0]  acc;

  for (genvar g = 0; g < FEATURES; g++) begin : g_term
    assign prod[g] = PROD_W'(x_i[g]) * PROD_W'(coeff_i[g]);
  end

  always_comb begin
    acc = '0;
    for (int f = 0; f < FEATURES; f++) begin
      acc = acc + ACC_W'(prod[f]);
    end
  end

  assign d_o = (acc >= thresh_i);

endmodule
`default_nettype wire

// File: rtl/dtree_mc.sv
`default_nettype none
// ============================================================================
// Module  : dtree_mc
// Purpose : Multi-channel decision-tree classifier; per-channel history,
//           programmable heap-ordered tree walked one level per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module dtree_mc
  import dtree_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int FEATURES    = DEF_FEATURES,
  parameter  int IN_WIDTH    = 10,
  parameter  int COEFF_WIDTH = 4,
  parameter  int DEPTH       = 3,
  localparam int NODES       = (1 << DEPTH) - 1,
  localparam int CH_W        = clog2(CHANNELS),
  localparam int ACC_W       = acc_w(IN_WIDTH, COEFF_WIDTH, FEATURES),
  localparam int NODE_W      = clog2(NODES),
  localparam int FIELD_W     = clog2(FEATURES + 2),
  localparam int LVL_W       = clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_sample,
  input  logic [CH_W-1:0]     in_channel,
  input  logic                cfg_we,
  input  logic [NODE_W-1:0]   cfg_node,
  input  logic [FIELD_W-1:0]  cfg_field,
  input  logic [ACC_W-1:0]    cfg_data,
  output logic                out_valid,
  output logic [LVL_W-1:0]    out_level,
  output logic [DEPTH-1:0]    out_path,
  output logic [CH_W-1:0]     out_channel
);

  localparam int FEAT_W = clog2(FEATURES);
  localparam logic [FIELD_W-1:0] F_NCOEF  = FIELD_W'(FEATURES);
  localparam logic [FIELD_W-1:0] F_THRESH = FIELD_W'(field_thresh(FEATURES));
  localparam logic [FIELD_W-1:0] F_LEAF   = FIELD_W'(field_leaf(FEATURES));

  state_e                        state_q;
  logic [NODE_W-1:0]             node_q;
  logic [LVL_W-1:0]              level_q;
  logic [DEPTH-1:0]              path_q;
  logic [CH_W-1:0]               ch_q;
  logic                          out_valid_q;
  logic [LVL_W-1:0]              out_level_q;
  logic [DEPTH-1:0]              out_path_q;
  logic [CH_W-1:0]               out_channel_q;

  logic signed [IN_WIDTH-1:0]    hist_q   [CHANNELS][FEATURES];
  logic signed [COEFF_WIDTH-1:0] coeff_q  [NODES][FEATURES];
  logic signed [ACC_W-1:0]       thresh_q [NODES];
  logic [NODES-1:0]              leaf_q;

  logic signed [IN_WIDTH-1:0]    sel_x [FEATURES];
  logic signed [COEFF_WIDTH-1:0] sel_c [FEATURES];
  logic                          dec;
  logic                          transfer;
  logic                          accept;
  logic                          cfg_wr;

  assign in_ready = (state_q == ST_IDLE);
  assign transfer = in_valid && in_ready;
  // Out-of-range channels are handshaken but otherwise discarded.
  assign accept   = transfer && ({1'b0, in_channel} < (CH_W + 1)'(CHANNELS));
  assign cfg_wr   = cfg_we && (state_q == ST_IDLE) &&
                    ({1'b0, cfg_node} < (NODE_W + 1)'(NODES));

  always_comb begin
    for (int f = 0; f < FEATURES; f++) begin
      sel_x[f] = hist_q[ch_q][f];
      sel_c[f] = coeff_q[node_q][f];
    end
  end

  dtree_node_eval #(
    .FEATURES    (FEATURES),
    .IN_WIDTH    (IN_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH)
  ) u_node_eval (
    .x_i      (sel_x),
    .coeff_i  (sel_c),
    .thresh_i (thresh_q[node_q]),
    .d_o      (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int f = 0; f < FEATURES; f++) hist_q[c][f] <= '0;
      end
      for (int n = 0; n < NODES; n++) begin
        thresh_q[n] <= '0;
        for (int f = 0; f < FEATURES; f++) coeff_q[n][f] <= '0;
      end
      leaf_q <= '0;
    end else begin
      if (cfg_wr) begin
        if (cfg_field < F_NCOEF) begin
          coeff_q[cfg_node][cfg_field[FEAT_W-1:0]] <= cfg_data[COEFF_WIDTH-1:0];
        end else if (cfg_field == F_THRESH) begin
          thresh_q[cfg_node] <= cfg_data;
        end else if (cfg_field == F_LEAF) begin
          leaf_q[cfg_node] <= cfg_data[0];
        end
      end
      if (accept) begin
        for (int f = FEATURES - 1; f > 0; f--) begin
          hist_q[in_channel][f] <= hist_q[in_channel][f-1];
        end
        hist_q[in_channel][0] <= in_sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      node_q        <= '0;
      level_q       <= '0;
      path_q        <= '0;
      ch_q          <= '0;
      out_valid_q   <= 1'b0;
      out_level_q   <= '0;
      out_path_q    <= '0;
      out_channel_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ch_q    <= in_channel;
            node_q  <= '0;
            level_q <= '0;
            path_q  <= '0;
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (level_q == LVL_W'(DEPTH) || leaf_q[node_q]) begin
            state_q <= ST_EMIT;
          end else begin
            path_q[level_q] <= dec;
            level_q         <= level_q + LVL_W'(1);
            // Skip the descent past the last level so node_q stays a valid index.
            if (level_q < LVL_W'(DEPTH - 1)) begin
              node_q <= (node_q << 1) + NODE_W'(1) + NODE_W'(dec);
            end
          end
        end
        ST_EMIT: begin
          out_valid_q   <= 1'b1;
          out_level_q   <= level_q;
          out_path_q    <= path_q;
          out_channel_q <= ch_q;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_level   = out_level_q;
  assign out_path    = out_path_q;
  assign out_channel = out_channel_q;

endmodule
`default_nettype wire
